// File: rtl/word_player_if.sv
`default_nettype none
// ============================================================================
//  Module   : word_player_if
//  Purpose  : Control / sequencer handshake bundle for word_player.
//             The slave modport is the player itself; the master modport is
//             the controller plus the upstream word sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface word_player_if;
  logic        start;
  logic        abort;
  logic [11:0] data_in;
  logic        go;
  logic [11:0] word_out;
  logic        word_valid;
  logic        busy;
  logic        done;

  modport slave (
    input  start,
    input  abort,
    input  data_in,
    output go,
    output word_out,
    output word_valid,
    output busy,
    output done
  );

  modport master (
    output start,
    output abort,
    output data_in,
    input  go,
    input  word_out,
    input  word_valid,
    input  busy,
    input  done
  );
endinterface
`default_nettype wire

// File: rtl/word_player.sv
`default_nettype none
// ============================================================================
//  Module   : word_player
//  Purpose  : Plays NWORDS control words from an upstream sequencer onto
//             word_out, holding each for DWELL cycles. Between words it
//             pulses go and waits LAT cycles for the sequencer to present
//             the next word, keeping the previous word applied meanwhile.
//  Revision : 1.0  initial release
// ============================================================================
module word_player #(
  parameter int unsigned DWELL  = 16,  // 1..65535
  parameter int unsigned NWORDS = 8,   // 1..15
  parameter int unsigned LAT    = 2    // 1..7
) (
  input  logic         clk,
  input  logic         rst,            // asynchronous, active-low
  word_player_if.slave bus
);

  // Reload values sized to the counters they are loaded into.
  localparam logic [15:0] c_dwell_init = 16'(DWELL - 1);
  localparam logic [2:0]  c_lat_init   = 3'(LAT - 1);
  localparam logic [3:0]  c_nwords     = 4'(NWORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_REQ  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_dwell;
  logic [2:0]  r_lat;
  logic [3:0]  r_wcnt;
  logic        r_go;
  logic [11:0] r_word;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;

  // Single-process FSM: every output is a register updated with the state.
  // go and done default low so they can only ever be one-cycle pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_dwell <= 16'd0;
      r_lat   <= 3'd0;
      r_wcnt  <= 4'd0;
      r_go    <= 1'b0;
      r_word  <= 12'h000;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_go   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // abort takes priority even here: start with abort never launches.
          if (bus.start && !bus.abort) begin
            r_word  <= bus.data_in;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_wcnt  <= 4'd1;
            r_dwell <= c_dwell_init;
            r_state <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (bus.abort) begin
            // Leave word_out on the last applied word.
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_dwell == 16'd0) begin
            if (r_wcnt < c_nwords) begin
              // go is registered, so it is high for exactly the REQ cycle.
              r_go    <= 1'b1;
              r_state <= S_REQ;
            end else begin
              r_done  <= 1'b1;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_dwell <= r_dwell - 16'd1;
          end
        end

        S_REQ: begin
          if (bus.abort) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_lat   <= c_lat_init;
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.abort) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_lat == 3'd0) begin
            // Sequencer output is valid now; swap in the next word.
            r_word  <= bus.data_in;
            r_wcnt  <= r_wcnt + 4'd1;
            r_dwell <= c_dwell_init;
            r_state <= S_HOLD;
          end else begin
            r_lat <= r_lat - 3'd1;
          end
        end

        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.go         = r_go;
  assign bus.word_out   = r_word;
  assign bus.word_valid = r_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_word_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_word_player
//  Purpose  : Self-checking bench for word_player. Two instances: default
//             parameters and a minimal DWELL=1/NWORDS=3/LAT=1 build. Expected
//             outputs come from a timeline model: a run is NWORDS slots of
//             DWELL hold cycles separated by 1+LAT transition cycles.
//  Revision : 1.0  initial release
// ============================================================================
module tb_word_player;

  localparam int c_dw0 = 16, c_nw0 = 8, c_lat0 = 2;
  localparam int c_dw1 = 1,  c_nw1 = 3, c_lat1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  word_player_if intf0();
  word_player_if intf1();

  word_player #(.DWELL(c_dw0), .NWORDS(c_nw0), .LAT(c_lat0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(intf0)
  );
  word_player #(.DWELL(c_dw1), .NWORDS(c_nw1), .LAT(c_lat1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(intf1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] words [16];

  // Packs {go, busy, word_valid, done, word_out}.
  task automatic get_out(input int sel, output logic [15:0] v);
    if (sel == 0) v = {intf0.go, intf0.busy, intf0.word_valid, intf0.done, intf0.word_out};
    else          v = {intf1.go, intf1.busy, intf1.word_valid, intf1.done, intf1.word_out};
  endtask

  task automatic set_ctrl(input int sel, input logic s, input logic a);
    if (sel == 0) begin intf0.start = s; intf0.abort = a; end
    else          begin intf1.start = s; intf1.abort = a; end
  endtask

  task automatic set_data(input int sel, input logic [11:0] d);
    if (sel == 0) intf0.data_in = d;
    else          intf1.data_in = d;
  endtask

  // Asynchronous assertion, zero outputs, clean release.
  task automatic test_reset();
    logic [15:0] got;
    #1 rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      get_out(s, got);
      n_checks++;
      if (got !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_async inst%0d: got %h expected 0000", s, got);
      end
    end
    set_ctrl(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    get_out(0, got);
    n_checks++;
    if (got !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected 0000", got);
    end
    set_ctrl(0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        get_out(s, got);
        n_checks++;
        if (got !== 16'h0000) begin
          n_fail++;
          $display("FAIL reset_release inst%0d cycle %0d: got %h expected 0000", s, c, got);
        end
      end
    end
  endtask

  // One run checked cycle by cycle against the timeline model. abort_at < 0
  // means no abort; otherwise abort is high during cycle abort_at (cycle 0 is
  // the first HOLD cycle). keep_start leaves start high throughout.
  task automatic run_case(input int sel, input int abort_at, input bit keep_start,
                          input string name);
    int dw, nw, lat, p, len, last, cd, idx;
    logic [15:0] got, exp;
    dw  = (sel == 0) ? c_dw0  : c_dw1;
    nw  = (sel == 0) ? c_nw0  : c_nw1;
    lat = (sel == 0) ? c_lat0 : c_lat1;
    p   = dw + 1 + lat;
    len = nw * dw + (nw - 1) * (1 + lat);
    for (int i = 0; i < nw; i++) words[i] = 12'($urandom);
    idx = 0;
    cd  = 0;
    exp = 16'h0000;
    set_data(sel, words[0]);
    set_ctrl(sel, 1'b1, 1'b0);
    @(posedge clk); #1;
    if (!keep_start) set_ctrl(sel, 1'b0, 1'b0);
    last = (abort_at < 0) ? len : abort_at + 1;
    for (int k = 0; k <= last; k++) begin
      get_out(sel, got);
      if (abort_at >= 0 && k == abort_at + 1)
        exp = {4'b0000, words[abort_at / p]};
      else if (k < len)
        exp = {((k % p) == dw), 1'b1, 1'b1, 1'b0, words[k / p]};
      else
        exp = {4'b0001, words[nw - 1]};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got go/busy/valid/done/word %b/%b/%b/%b/%h expected %b/%b/%b/%b/%h",
                 name, k, got[15], got[14], got[13], got[12], got[11:0],
                 exp[15], exp[14], exp[13], exp[12], exp[11:0]);
      end
      // Upstream sequencer: next word appears LAT cycles after a go pulse.
      if (cd > 0) begin
        cd--;
        if (cd == 0 && idx < nw - 1) begin
          idx++;
          set_data(sel, words[idx]);
        end
      end
      if (got[15] === 1'b1) cd = lat;
      set_ctrl(sel, keep_start, (k == abort_at));
      if (k < last) begin
        @(posedge clk); #1;
      end
    end
    if (keep_start) begin
      // start still high in the done cycle: a new run begins right away.
      @(posedge clk); #1;
      get_out(sel, got);
      exp = {4'b0110, words[nw - 1]};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s restart: got %h expected %h", name, got, exp);
      end
      set_ctrl(sel, 1'b0, 1'b1);
      @(posedge clk); #1;
      set_ctrl(sel, 1'b0, 1'b0);
      get_out(sel, got);
      exp = {4'b0000, words[nw - 1]};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s restart_abort: got %h expected %h", name, got, exp);
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      get_out(sel, got);
      n_checks++;
      if (got !== {4'b0000, exp[11:0]}) begin
        n_fail++;
        $display("FAIL %s idle_after cycle %0d: got %h expected %h", name, c, got,
                 {4'b0000, exp[11:0]});
      end
    end
  endtask

  // abort alone, and start together with abort, must not leave IDLE.
  task automatic test_idle_abort();
    logic [15:0] got;
    set_data(1, 12'($urandom));
    for (int c = 0; c < 4; c++) begin
      set_ctrl(1, (c < 2), 1'b1);
      @(posedge clk); #1;
      get_out(1, got);
      n_checks++;
      if (got[15:12] !== 4'b0000) begin
        n_fail++;
        $display("FAIL idle_abort cycle %0d: got flags %b expected 0000", c, got[15:12]);
      end
    end
    set_ctrl(1, 1'b0, 1'b0);
  endtask

  // Reset pulled between clock edges while the player waits on the sequencer.
  task automatic test_reset_midrun();
    logic [15:0] got;
    set_data(0, 12'($urandom));
    set_ctrl(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_ctrl(0, 1'b0, 1'b0);
    for (int k = 0; k < c_dw0 + 1; k++) begin
      @(posedge clk); #1;
    end
    get_out(0, got);
    n_checks++;
    if (got[15:12] !== 4'b0110) begin
      n_fail++;
      $display("FAIL midrun_in_wait: got flags %b expected 0110", got[15:12]);
    end
    #3 rst = 1'b0;
    #1;
    get_out(0, got);
    n_checks++;
    if (got !== 16'h0000) begin
      n_fail++;
      $display("FAIL midrun_reset_async: got %h expected 0000", got);
    end
    @(posedge clk); #1;
    get_out(0, got);
    n_checks++;
    if (got !== 16'h0000) begin
      n_fail++;
      $display("FAIL midrun_reset_held: got %h expected 0000", got);
    end
    #3 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      get_out(0, got);
      n_checks++;
      if (got !== 16'h0000) begin
        n_fail++;
        $display("FAIL midrun_release cycle %0d: got %h expected 0000", c, got);
      end
    end
    run_case(0, -1, 1'b0, "post_reset_run");
  endtask

  initial begin
    set_ctrl(0, 1'b0, 1'b0);
    set_ctrl(1, 1'b0, 1'b0);
    set_data(0, 12'h000);
    set_data(1, 12'h000);
    test_reset();
    run_case(0, -1, 1'b0, "default_run");
    run_case(1, -1, 1'b0, "short_run");
    test_idle_abort();
    run_case(0, (c_dw0 + 1 + c_lat0) + 2, 1'b0, "abort_hold_word2");
    run_case(0, c_nw0 * c_dw0 + (c_nw0 - 1) * (1 + c_lat0) - 1, 1'b0, "abort_final");
    run_case(1, c_nw1 * c_dw1 + (c_nw1 - 1) * (1 + c_lat1) - 1, 1'b0, "abort_final_short");
    run_case(1, 2, 1'b0, "abort_wait_short");
    run_case(1, -1, 1'b1, "start_held");
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/word_player.md
WORD_PLAYER -- requirements
Module: word_player

Interface
REQ-001 Parameter: DWELL, default 16; cycles each captured control word is held on word_out (range 1..65535).
REQ-002 Parameter: NWORDS, default 8; words played per run (range 1..15).
REQ-003 Parameter: LAT, default 2; cycles from a go pulse until the upstream sequencer presents the next word on data_in (range 1..7).
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  in  1  reset; asynchronous, active-low.
REQ-006 Port: start  in  1  level sampled in IDLE; high begins a run.
REQ-007 Port: abort  in  1  high ends a run from any non-IDLE state.
REQ-008 Port: data_in  in  12  control word from the upstream sequencer.
REQ-009 Port: go  out  1  one-cycle pulse telling the upstream sequencer to advance one word.
REQ-010 Port: word_out  out  12  control word currently applied downstream.
REQ-011 Port: word_valid  out  1  high while word_out holds a captured word of the current run.
REQ-012 Port: busy  out  1  high in every state except IDLE.
REQ-013 Port: done  out  1  one-cycle pulse at normal run completion.

Function
REQ-014 FSM states SHALL be IDLE, HOLD, REQ, WAIT; all outputs registered.
REQ-015 IDLE with start=1 SHALL capture data_in into word_out, set word_valid=1, clear word count to 1, load dwell counter with DWELL-1, and enter HOLD next cycle.
REQ-016 HOLD SHALL decrement the dwell counter each cycle; at 0 it SHALL enter REQ if word count < NWORDS, else pulse done for one cycle, clear word_valid, and enter IDLE.
REQ-017 REQ SHALL last exactly one cycle with go=1, load the latency counter with LAT-1, and enter WAIT; go SHALL be 0 in every other state.
REQ-018 WAIT SHALL decrement the latency counter; at 0 it SHALL capture data_in into word_out, increment word count, reload the dwell counter with DWELL-1, and enter HOLD.
REQ-019 During WAIT, word_out SHALL keep the previous word and word_valid SHALL remain 1.
REQ-020 Hence each word is held exactly DWELL cycles in HOLD, and consecutive words are separated by 1+LAT transition cycles.
REQ-021 Total go pulses per completed run SHALL equal NWORDS-1.
REQ-022 abort=1 in any non-IDLE state SHALL enter IDLE next cycle, clear word_valid, suppress done and go that cycle; word_out SHALL keep its last value.
REQ-023 abort and the dwell-expiry done condition in the same cycle: abort SHALL win (no done pulse).
REQ-024 abort in IDLE SHALL be ignored; start=1 together with abort=1 in IDLE SHALL not start a run.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 Dwell counter SHALL be 16 bits, latency counter 3 bits, word count 4 bits; none SHALL wrap within a legal run.
REQ-027 DWELL=1 SHALL give exactly one HOLD cycle per word.

Reset
REQ-028 rst low SHALL immediately force IDLE, go=0, done=0, busy=0, word_valid=0, word_out=12'h000, all counters 0, independent of clk.
REQ-029 Reset asserted mid-run SHALL abandon the run; after release the block SHALL wait in IDLE for start.
REQ-030 Release of rst SHALL take effect on the first rising clk edge after deassertion with no spurious go or done pulse.

Verification
REQ-031 Defaults, sequencer model with LAT=2, start pulse -> word_out steps through 8 words, each held 16 cycles, 7 go pulses, done pulse 1 cycle after last dwell, busy falls same cycle.
REQ-032 DWELL=1, NWORDS=3, LAT=1 -> go spacing exactly 3 cycles, 2 go pulses, done after 7 busy cycles.
REQ-033 abort in 3rd HOLD cycle of word 2 -> IDLE next cycle, word_valid=0, no further go, no done, word_out unchanged.
REQ-034 abort coincident with final dwell expiry -> no done pulse, IDLE next cycle.
REQ-035 rst asserted in WAIT between clk edges -> outputs zero immediately; go never asserted; start after release runs normally from word 1.
REQ-036 start held high throughout a run -> no restart while busy; new run begins the cycle after return to IDLE.
